mlp_run_ctrl: RTL

Top-level run controller for the MLP inference core. Accepts a start request and a 16-sample input vector stream, loads it into layer 0 of the neuron RAM, then releases the layer/neuron/weight sequencing engine from reset and shares the single neuron-RAM write port between the load path and the engine's writeback path. It captures the output-layer result, signals completion, and aborts via a watchdog if the engine never finishes.

---
 rtl/mlp_pkg.sv | 12 +
 rtl/mlp_run_ctrl_if.sv | 24 ++
 rtl/mlp_wport_mux.sv | 34 +++
 rtl/mlp_run_ctrl.sv | 91 +++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// mlp_pkg: shared types and constants for the MLP inference core.
package mlp_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_FINISH} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_LOAD, OWN_ENG} owner_e;
  // The layer index occupies the top LAYER_W bits of a neuron address.
  localparam int LAYER_W = 2;
  localparam logic [LAYER_W-1:0] LAYER_IN = 2'd0;
  localparam logic [LAYER_W-1:0] LAYER_OUT = 2'd3;
  localparam int DEF_N_IN = 16;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 12;
endpackage

// File: rtl/mlp_run_ctrl_if.sv
// mlp_run_ctrl_if: input stream, engine and neuron-RAM write-port signals of the run controller.
interface mlp_run_ctrl_if #(
  parameter int DATA_W = mlp_pkg::DEF_DATA_W,
  parameter int ADDR_W = mlp_pkg::DEF_ADDR_W
);
  logic start, in_valid, in_ready;
  logic [DATA_W-1:0] in_data;
  logic eng_reset, eng_done, eng_write_neuron;
  logic [ADDR_W-1:0] eng_out_addr;
  logic [DATA_W-1:0] acc_data;
  logic neuron_we;
  logic [ADDR_W-1:0] neuron_waddr;
  logic [DATA_W-1:0] neuron_wdata;
  logic busy, done, err;
  logic [DATA_W-1:0] result;
  modport master (
    output start, in_valid, in_data, eng_done, eng_write_neuron, eng_out_addr, acc_data,
    input in_ready, eng_reset, neuron_we, neuron_waddr, neuron_wdata, busy, done, err, result
  );
  modport slave (
    input start, in_valid, in_data, eng_done, eng_write_neuron, eng_out_addr, acc_data,
    output in_ready, eng_reset, neuron_we, neuron_waddr, neuron_wdata, busy, done, err, result
  );
endinterface

// File: rtl/mlp_wport_mux.sv
// mlp_wport_mux: registered neuron-RAM write port shared by the load path and engine writeback.
module mlp_wport_mux import mlp_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  owner_e            owner,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              eng_valid,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [DATA_W-1:0] eng_data,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
);
  logic sel_load, sel_eng;
  assign sel_load = owner == OWN_LOAD && load_valid;
  assign sel_eng  = owner == OWN_ENG && eng_valid;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      we <= sel_load || sel_eng;
      if (sel_load || sel_eng) begin
        waddr <= sel_load ? load_addr : eng_addr;
        wdata <= sel_load ? load_data : eng_data;
      end
    end
endmodule

// File: rtl/mlp_run_ctrl.sv
// mlp_run_ctrl: run controller that loads layer 0, runs the engine, captures the output neuron
// and aborts via a watchdog.
module mlp_run_ctrl import mlp_pkg::*; #(
  parameter int N_IN       = DEF_N_IN,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int MAC_LAT    = 2,
  parameter int MAX_CYCLES = 1024
) (
  input logic          clk,
  input logic          reset_n,
  mlp_run_ctrl_if.slave bus
);
  localparam int CW = $clog2(N_IN);
  localparam int WW = $clog2(MAX_CYCLES);
  localparam int DW = $clog2(MAC_LAT + 1);
  state_e state, nxt;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wd;
  logic [DW-1:0] dcnt;
  logic seen, err_q, beat, eng_own, cap, last_beat, wd_exp, drain_end;
  logic [DATA_W-1:0] res;
  owner_e owner;
  assign beat      = bus.in_valid && state == S_LOAD;
  assign last_beat = beat && cnt == CW'(N_IN - 1);
  assign eng_own   = state == S_COMPUTE || state == S_DRAIN;
  assign cap       = eng_own && bus.eng_write_neuron && !seen &&
                     bus.eng_out_addr[ADDR_W-1 -: LAYER_W] == LAYER_OUT;
  assign wd_exp    = wd == WW'(MAX_CYCLES - 1);
  assign drain_end = state == S_DRAIN && dcnt == DW'(MAC_LAT - 1);
  assign owner     = state == S_LOAD ? OWN_LOAD : eng_own ? OWN_ENG : OWN_NONE;
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:    nxt = bus.start ? S_LOAD : S_IDLE;
      S_LOAD:    nxt = last_beat ? S_COMPUTE : S_LOAD;
      S_COMPUTE: nxt = bus.eng_done ? S_DRAIN : wd_exp ? S_FINISH : S_COMPUTE;
      S_DRAIN:   nxt = drain_end ? S_FINISH : S_DRAIN;
      default:   nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt   <= '0;
      wd    <= '0;
      dcnt  <= '0;
      seen  <= 1'b0;
      err_q <= 1'b0;
      res   <= '0;
    end else begin
      if (state == S_IDLE && bus.start) begin
        cnt  <= '0;
        wd   <= '0;
        seen <= 1'b0;
      end
      if (beat) cnt <= cnt + 1'b1;
      if (state == S_COMPUTE && !wd_exp) wd <= wd + 1'b1;
      dcnt <= state == S_DRAIN ? dcnt + 1'b1 : '0;
      // The previous run's result stays visible until new input data starts arriving.
      if (beat && cnt == '0) res <= '0;
      if (cap) begin
        res  <= bus.acc_data;
        seen <= 1'b1;
      end
      if (state == S_COMPUTE && !bus.eng_done && wd_exp) err_q <= 1'b1;
      else if (drain_end) err_q <= !(seen || cap);
    end
  mlp_wport_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_wport (
    .clk        (clk),
    .reset_n    (reset_n),
    .owner      (owner),
    .load_valid (bus.in_valid),
    .load_addr  ({LAYER_IN, (ADDR_W - LAYER_W)'(cnt)}),
    .load_data  (bus.in_data),
    .eng_valid  (bus.eng_write_neuron),
    .eng_addr   (bus.eng_out_addr),
    .eng_data   (bus.acc_data),
    .we         (bus.neuron_we),
    .waddr      (bus.neuron_waddr),
    .wdata      (bus.neuron_wdata)
  );
  assign bus.in_ready  = state == S_LOAD;
  assign bus.busy      = state != S_IDLE;
  assign bus.done      = state == S_FINISH;
  assign bus.err       = state == S_FINISH && err_q;
  assign bus.eng_reset = !eng_own;
  assign bus.result    = res;
endmodule
